// File: rtl/ram_bus_pkg.sv
// Shared state encoding and response latencies for the RAM bus initiator.
// Latencies count cycles from the request-accept cycle to the first rsp_valid cycle.
package ram_bus_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WR,
      RD_ADDR,
      RD_DATA,
      RSP
   } ram_bus_state_t;

   localparam int RD_LATENCY = 3;
   localparam int WR_LATENCY = 2;

endpackage

// File: rtl/ram_bus_master.sv
// Single-beat read/write initiator for the synchronous single-port RAM bus.
// Latency: write response 2 cycles, read response 3 cycles after the accept cycle.
// Backpressure: one transaction in flight; req_ready stays low until the response is taken.
module ram_bus_master
   import ram_bus_pkg::*;
#(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic                  rsp_we,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   inout  wire  [DATA_WIDTH-1:0] mem_data,
   output logic                  mem_cs,
   output logic                  mem_we,
   output logic                  mem_oe
);

   ram_bus_state_t        state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic                  mem_cs_q, mem_cs_d;
   logic                  mem_we_q, mem_we_d;
   logic                  mem_oe_q, mem_oe_d;
   logic                  rsp_valid_q, rsp_valid_d;
   logic                  rsp_we_q, rsp_we_d;
   logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      rsp_we_d    = rsp_we_q;
      rsp_rdata_d = rsp_rdata_q;
      unique case (state_q)
         IDLE: begin
            if (req_valid) begin
               addr_d  = req_addr;
               wdata_d = req_wdata;
               state_d = req_we ? WR : RD_ADDR;
            end
         end
         WR: begin
            state_d     = RSP;
            rsp_we_d    = 1'b1;
            rsp_rdata_d = '0;
         end
         RD_ADDR: state_d = RD_DATA;
         RD_DATA: begin
            // RAM output register was loaded at the end of RD_ADDR
            state_d     = RSP;
            rsp_we_d    = 1'b0;
            rsp_rdata_d = mem_data;
         end
         RSP: begin
            if (rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Pins are registered from the next state so they change only on clock edges
      mem_cs_d    = (state_d == WR) || (state_d == RD_ADDR) || (state_d == RD_DATA);
      mem_we_d    = (state_d == WR);
      mem_oe_d    = (state_d == RD_ADDR) || (state_d == RD_DATA);
      rsp_valid_d = (state_d == RSP);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         wdata_q     <= '0;
         mem_cs_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_oe_q    <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_we_q    <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         mem_cs_q    <= mem_cs_d;
         mem_we_q    <= mem_we_d;
         mem_oe_q    <= mem_oe_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_we_q    <= rsp_we_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   end

   // Master drives the data bus only during WR, which is exactly when mem_we is high
   assign mem_data  = mem_we_q ? wdata_q : 'z;

   assign req_ready = rst_n && (state_q == IDLE);
   assign rsp_valid = rsp_valid_q;
   assign rsp_we    = rsp_we_q;
   assign rsp_rdata = rsp_rdata_q;
   assign mem_addr  = addr_q;
   assign mem_cs    = mem_cs_q;
   assign mem_we    = mem_we_q;
   assign mem_oe    = mem_oe_q;

endmodule
